// File: rtl/coin_input_conditioner_pkg.sv
// Shared channel numbering and helpers for the coin input conditioner.
// Channel index order doubles as arbitration priority (lowest index wins).
package coin_input_pkg;

  localparam int NUM_CH = 5;
  localparam int CH_M   = 0;
  localparam int CH_N   = 1;
  localparam int CH_L   = 2;
  localparam int CH_R   = 3;
  localparam int CH_C   = 4;
  localparam int GAP_W  = 4;

  typedef logic [NUM_CH-1:0] ch_vec_t;

  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

  // One-hot of the lowest-index set bit, i.e. the highest-priority requester.
  function automatic ch_vec_t first_set(input ch_vec_t req);
    ch_vec_t grant;
    grant = {NUM_CH{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = {NUM_CH{1'b0}};
        grant[i] = 1'b1;
      end else begin
        grant = grant;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/coin_input_conditioner_if.sv
// Raw sensor lines in, conditioned FSM pulses and status out.
interface coin_input_conditioner_if;

  logic M_RAW;
  logic N_RAW;
  logic C_RAW;
  logic R_RAW;
  logic L_RAW;
  logic M;
  logic N;
  logic C;
  logic R;
  logic L;
  logic DROP;
  logic BUSY;

  modport master (
    output M_RAW, N_RAW, C_RAW, R_RAW, L_RAW,
    input  M, N, C, R, L, DROP, BUSY
  );

  modport slave (
    input  M_RAW, N_RAW, C_RAW, R_RAW, L_RAW,
    output M, N, C, R, L, DROP, BUSY
  );

endinterface

// File: rtl/coin_input_conditioner_debounce_channel.sv
// One sensor line: 2-flop synchronizer, debounce counter and a strobe that is
// high during the cycle whose closing edge accepts a debounced 0->1 change.
module debounce_channel
  import coin_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  assign accept_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);
  assign rise     = accept_s && sync2_r;

  // Synchronize the raw line and require a run of stable samples before moving the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (accept_s) begin
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else if (sync2_r != level_r) begin
        cnt_r   <= cnt_r + CW'(1);
      end else begin
        cnt_r   <= {CW{1'b0}};
      end
    end
  end

endmodule

// File: rtl/coin_input_conditioner.sv
// Five debounced sensor channels feeding a pending vector, a fixed-priority
// arbiter and an idle-gap counter so the FSM sees at most one pulse per cycle.
module coin_input_conditioner
  import coin_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP             = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  coin_input_conditioner_if.slave  bus
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

  ch_vec_t          raw_s;
  ch_vec_t          rise_s;
  ch_vec_t          grant_s;
  ch_vec_t          pending_r;
  ch_vec_t          pulse_r;
  logic [GAP_W-1:0] gap_r;
  logic             drop_r;
  logic             busy_r;

  assign raw_s[CH_M] = bus.M_RAW;
  assign raw_s[CH_N] = bus.N_RAW;
  assign raw_s[CH_L] = bus.L_RAW;
  assign raw_s[CH_R] = bus.R_RAW;
  assign raw_s[CH_C] = bus.C_RAW;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk (CLK),
      .rst (RST),
      .raw (raw_s[i]),
      .rise(rise_s[i])
    );
  end

  // Pick the highest-priority pending channel once the gap has run out.
  always_comb begin
    grant_s = {NUM_CH{1'b0}};
    if (gap_r == {GAP_W{1'b0}}) begin
      grant_s = first_set(pending_r);
    end else begin
      grant_s = {NUM_CH{1'b0}};
    end
  end

  // A rise on a channel being granted this edge re-arms it instead of dropping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_r <= {NUM_CH{1'b0}};
      pulse_r   <= {NUM_CH{1'b0}};
      gap_r     <= {GAP_W{1'b0}};
      drop_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~grant_s) | rise_s;
      pulse_r   <= grant_s;
      drop_r    <= |(rise_s & pending_r & ~grant_s);
      busy_r    <= (|pending_r) || (gap_r != {GAP_W{1'b0}});
      if (|grant_s) begin
        gap_r <= GAP_LOAD;
      end else if (gap_r != {GAP_W{1'b0}}) begin
        gap_r <= gap_r - GAP_W'(1);
      end else begin
        gap_r <= gap_r;
      end
    end
  end

  assign bus.M    = pulse_r[CH_M];
  assign bus.N    = pulse_r[CH_N];
  assign bus.L    = pulse_r[CH_L];
  assign bus.R    = pulse_r[CH_R];
  assign bus.C    = pulse_r[CH_C];
  assign bus.DROP = drop_r;
  assign bus.BUSY = busy_r;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scoreboard bench: three conditioner instances (GAP 1, 15, 0) driven by
// directed presses; a negedge monitor pops expected pulses as they appear.
module tb_coin_input_conditioner;

  localparam int K_M = 0, K_N = 1, K_L = 2, K_R = 3, K_C = 4, K_DROP = 5;

  typedef struct packed {
    int inst;
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   base;
  ev_t  exp_q[$];

  coin_input_conditioner_if ia ();
  coin_input_conditioner_if ib ();
  coin_input_conditioner_if ic ();

  coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP(1)) dut_a (
    .CLK(clk), .RST(rst), .bus(ia.slave)
  );
  coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP(15)) dut_b (
    .CLK(clk), .RST(rst), .bus(ib.slave)
  );
  coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP(0)) dut_c (
    .CLK(clk), .RST(rst), .bus(ic.slave)
  );

  logic [5:0] obs [3];
  assign obs[0] = {ia.DROP, ia.C, ia.R, ia.L, ia.N, ia.M};
  assign obs[1] = {ib.DROP, ib.C, ib.R, ib.L, ib.N, ib.M};
  assign obs[2] = {ic.DROP, ic.C, ic.R, ic.L, ic.N, ic.M};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int inst, input int kind, input int c);
    exp_q.push_back('{inst: inst, kind: kind, cyc: c});
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every high output must match the head of the expected queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 6; k++) begin
          if (obs[i][k] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_pulse: got inst=%0d kind=%0d cyc=%0d expected none",
                       i, k, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.inst != i || e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL pulse: got inst=%0d kind=%0d cyc=%0d expected inst=%0d kind=%0d cyc=%0d",
                         i, k, cyc, e.inst, e.kind, e.cyc);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    {ia.M_RAW, ia.N_RAW, ia.C_RAW, ia.R_RAW, ia.L_RAW} = 5'b0;
    {ib.M_RAW, ib.N_RAW, ib.C_RAW, ib.R_RAW, ib.L_RAW} = 5'b0;
    {ic.M_RAW, ic.N_RAW, ic.C_RAW, ic.R_RAW, ic.L_RAW} = 5'b0;
    tick(3);
    for (int i = 0; i < 3; i++) chk("reset_pulses", int'(obs[i]), 0);
    chk("reset_busy_a", int'(ia.BUSY), 0);
    chk("reset_busy_b", int'(ib.BUSY), 0);
    chk("reset_busy_c", int'(ic.BUSY), 0);
    rst = 1'b0;
    tick(2);

    // Clean press: single M pulse 7 edges after the first sampling edge.
    base = cyc;
    push(0, K_M, base + 7);
    ia.M_RAW = 1'b1;
    tick(20);
    ia.M_RAW = 1'b0;
    tick(20);
    chk("drain_clean", exp_q.size(), 0);

    // Bounce then hold: one R pulse timed from the final stable rise.
    ia.R_RAW = 1'b1; tick(1);
    ia.R_RAW = 1'b0; tick(1);
    ia.R_RAW = 1'b1; tick(1);
    ia.R_RAW = 1'b0; tick(1);
    base = cyc;
    push(0, K_R, base + 7);
    ia.R_RAW = 1'b1;
    tick(50);
    ia.R_RAW = 1'b0;
    tick(20);
    chk("drain_bounce", exp_q.size(), 0);

    // Collision: N wins, C follows after one idle cycle.
    base = cyc;
    push(0, K_N, base + 7);
    push(0, K_C, base + 9);
    ia.N_RAW = 1'b1;
    ia.C_RAW = 1'b1;
    tick(7);
    chk("busy_coll_7", int'(ia.BUSY), 1);
    tick(1);
    chk("busy_coll_8", int'(ia.BUSY), 1);
    tick(1);
    chk("busy_coll_9", int'(ia.BUSY), 1);
    tick(10);
    ia.N_RAW = 1'b0;
    ia.C_RAW = 1'b0;
    tick(20);
    chk("drain_collision", exp_q.size(), 0);

    // Drop with GAP=15: third L press lands while the second is still pending.
    base = cyc;
    push(1, K_L, base + 7);
    push(1, K_DROP, base + 22);
    push(1, K_L, base + 23);
    ib.L_RAW = 1'b1; tick(4);
    ib.L_RAW = 1'b0; tick(4);
    ib.L_RAW = 1'b1; tick(4);
    ib.L_RAW = 1'b0; tick(4);
    ib.L_RAW = 1'b1; tick(20);
    ib.L_RAW = 1'b0;
    tick(30);
    chk("drain_drop", exp_q.size(), 0);

    // Reset at edge 4 of an M press aborts it; held line re-presses afterwards.
    base = cyc;
    ia.M_RAW = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_pulses", int'(obs[0]), 0);
    chk("rst_mid_busy", int'(ia.BUSY), 0);
    rst = 1'b0;
    push(0, K_M, base + 11);
    tick(20);
    ia.M_RAW = 1'b0;
    tick(20);
    chk("drain_reset", exp_q.size(), 0);

    // GAP=0 backlog: five back-to-back pulses in priority order.
    base = cyc;
    push(2, K_M, base + 7);
    push(2, K_N, base + 8);
    push(2, K_L, base + 9);
    push(2, K_R, base + 10);
    push(2, K_C, base + 11);
    {ic.M_RAW, ic.N_RAW, ic.C_RAW, ic.R_RAW, ic.L_RAW} = 5'b11111;
    tick(11);
    chk("busy_backlog_c", int'(ic.BUSY), 1);
    tick(1);
    chk("busy_backlog_after", int'(ic.BUSY), 0);
    tick(10);
    {ic.M_RAW, ic.N_RAW, ic.C_RAW, ic.R_RAW, ic.L_RAW} = 5'b0;
    tick(20);
    chk("drain_backlog", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
